// File: rtl/alu_muldiv_if.sv
// Execute-stage bus of alu_muldiv: instruction operands/controls toward the ALU,
// result, flags and mul/div status back toward the pipeline.
interface alu_muldiv_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               in_valid;
  logic               ALUSrc;
  logic [WIDTH-1:0]   SrcA;
  logic [WIDTH-1:0]   RD2;
  logic [WIDTH-1:0]   SignImm;
  logic [SHAMT_W-1:0] sa;
  logic [4:0]         ALUControl;
  logic [WIDTH-1:0]   ALUResult;
  logic               Zero;
  logic               overflow;
  logic               busy;
  logic               stall;
  logic               done;
  logic [WIDTH-1:0]   hi_out;
  logic [WIDTH-1:0]   lo_out;

  modport master (
    output in_valid, ALUSrc, SrcA, RD2, SignImm, sa, ALUControl,
    input  ALUResult, Zero, overflow, busy, stall, done, hi_out, lo_out
  );

  modport slave (
    input  in_valid, ALUSrc, SrcA, RD2, SignImm, sa, ALUControl,
    output ALUResult, Zero, overflow, busy, stall, done, hi_out, lo_out
  );
endinterface

// File: rtl/alu_muldiv.sv
// MIPS execute-stage ALU with a radix-2 multi-cycle multiply/divide engine and HI/LO.
// Optional feature macro ALU_MULDIV_HILO_WRITE_EN enables MTHI/MTLO (codes 10110/10111).
module alu_muldiv #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  alu_muldiv_if.slave bus
);
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_ADDU = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_SUBU = 5'b00011;
  localparam logic [4:0] OP_AND  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b00101;
  localparam logic [4:0] OP_SLL  = 5'b00110;
  localparam logic [4:0] OP_SRL  = 5'b00111;
  localparam logic [4:0] OP_SLT  = 5'b01000;
  localparam logic [4:0] OP_BEQ  = 5'b01001;
  localparam logic [4:0] OP_BNE  = 5'b01010;
  localparam logic [4:0] OP_SRA  = 5'b01011;
  localparam logic [4:0] OP_SLTU = 5'b01100;
  localparam logic [4:0] OP_XOR  = 5'b01101;
  localparam logic [4:0] OP_NOR  = 5'b01110;
  localparam logic [4:0] OP_MFHI = 5'b10100;
  localparam logic [4:0] OP_MFLO = 5'b10101;
  localparam logic [4:0] OP_MTHI = 5'b10110;
  localparam logic [4:0] OP_MTLO = 5'b10111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               busy_s, is_muldiv_s, is_mfhilo_s, is_mthilo_s;
  logic               accept_s, stall_s, mt_wr_s;
  logic               op_signed_s, a_neg_s, b_neg_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [WIDTH:0]     mul_sum_s, div_shift_s, div_trial_s;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;
  logic               addsub_class_s, do_sub_s;
  logic [WIDTH-1:0]   b_add_s, addsub_res_s, res_s;
  logic               ovf_add_s, ovf_sub_s;

  assign busy_s      = (state_q != ST_IDLE);
  assign is_muldiv_s = (bus.ALUControl[4:2] == 3'b100);
  assign is_mfhilo_s = (bus.ALUControl == OP_MFHI) || (bus.ALUControl == OP_MFLO);
`ifdef ALU_MULDIV_HILO_WRITE_EN
  assign is_mthilo_s = (bus.ALUControl == OP_MTHI) || (bus.ALUControl == OP_MTLO);
`else
  assign is_mthilo_s = 1'b0;
`endif
  assign accept_s = bus.in_valid & is_muldiv_s & ~busy_s;
  assign mt_wr_s  = bus.in_valid & is_mthilo_s & ~busy_s;
  assign stall_s  = bus.in_valid & busy_s & (is_muldiv_s | is_mfhilo_s | is_mthilo_s);

  // The engine works on magnitudes; signs are remembered and re-applied in FIX.
  assign op_signed_s = ~bus.ALUControl[0];
  assign a_neg_s     = op_signed_s & bus.SrcA[WIDTH-1];
  assign b_neg_s     = op_signed_s & bus.RD2[WIDTH-1];
  assign a_mag_s     = a_neg_s ? (-bus.SrcA) : bus.SrcA;
  assign b_mag_s     = b_neg_s ? (-bus.RD2) : bus.RD2;

  assign mul_sum_s   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
  assign div_shift_s = {acc_q, mq_q[WIDTH-1]};
  assign div_trial_s = div_shift_s - {1'b0, opb_q};
  assign prod_s      = {acc_q, mq_q};
  assign prod_fix_s  = neg_res_q ? (-prod_s) : prod_s;

  // Engine next state: latch on accept, one radix-2 step per ITER cycle, sign fix in FIX.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    opb_d     = opb_q;
    dvd_d     = dvd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d   = ST_ITER;
          cnt_d     = SHAMT_W'(WIDTH - 1);
          acc_d     = {WIDTH{1'b0}};
          mq_d      = a_mag_s;
          opb_d     = b_mag_s;
          dvd_d     = bus.SrcA;
          is_div_d  = bus.ALUControl[1];
          neg_res_d = a_neg_s ^ b_neg_s;
          neg_rem_d = a_neg_s;
          div0_d    = (bus.RD2 == {WIDTH{1'b0}});
        end else if (mt_wr_s) begin
          if (bus.ALUControl[0]) begin
            lo_d = bus.SrcA;
          end else begin
            hi_d = bus.SrcA;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ITER: begin
        if (is_div_q) begin
          if (!div_trial_s[WIDTH]) begin
            acc_d = div_trial_s[WIDTH-1:0];
            mq_d  = {mq_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = div_shift_s[WIDTH-1:0];
            mq_d  = {mq_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = mul_sum_s[WIDTH:1];
          mq_d  = {mul_sum_s[0], mq_q[WIDTH-1:1]};
        end
        if (cnt_q == {SHAMT_W{1'b0}}) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - SHAMT_W'(1);
        end
      end
      ST_FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
          lo_d = prod_fix_s[WIDTH-1:0];
        end else if (div0_q) begin
          hi_d = dvd_q;
          lo_d = {WIDTH{1'b1}};
        end else begin
          hi_d = neg_rem_q ? (-acc_q) : acc_q;
          lo_d = neg_res_q ? (-mq_q) : mq_q;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {SHAMT_W{1'b0}};
      acc_q     <= {WIDTH{1'b0}};
      mq_q      <= {WIDTH{1'b0}};
      opb_q     <= {WIDTH{1'b0}};
      dvd_q     <= {WIDTH{1'b0}};
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      opb_q     <= opb_d;
      dvd_q     <= dvd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  // Only the add/sub class honours ALUSrc; branches and SLT compare against RD2.
  assign addsub_class_s = (bus.ALUControl[4:2] == 3'b000);
  assign b_add_s        = (addsub_class_s && bus.ALUSrc) ? bus.SignImm : bus.RD2;
  assign do_sub_s       = (bus.ALUControl == OP_SUB) || (bus.ALUControl == OP_SUBU) ||
                          (bus.ALUControl == OP_BEQ) || (bus.ALUControl == OP_BNE);
  assign addsub_res_s   = do_sub_s ? (bus.SrcA - b_add_s) : (bus.SrcA + b_add_s);
  assign ovf_add_s      = (bus.SrcA[WIDTH-1] == b_add_s[WIDTH-1]) &&
                          (addsub_res_s[WIDTH-1] != bus.SrcA[WIDTH-1]);
  assign ovf_sub_s      = (bus.SrcA[WIDTH-1] != b_add_s[WIDTH-1]) &&
                          (addsub_res_s[WIDTH-1] != bus.SrcA[WIDTH-1]);

  // Single-cycle result mux.
  always_comb begin
    res_s = {WIDTH{1'b0}};
    case (bus.ALUControl)
      OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_BEQ, OP_BNE: res_s = addsub_res_s;
      OP_AND:  res_s = bus.SrcA & bus.RD2;
      OP_OR:   res_s = bus.SrcA | bus.RD2;
      OP_XOR:  res_s = bus.SrcA ^ bus.RD2;
      OP_NOR:  res_s = ~(bus.SrcA | bus.RD2);
      OP_SLL:  res_s = bus.RD2 << bus.sa;
      OP_SRL:  res_s = bus.RD2 >> bus.sa;
      OP_SRA:  res_s = $signed(bus.RD2) >>> bus.sa;
      OP_SLT:  res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.SrcA) < $signed(bus.RD2))};
      OP_SLTU: res_s = {{(WIDTH-1){1'b0}}, (bus.SrcA < bus.RD2)};
      OP_MFHI: res_s = busy_s ? {WIDTH{1'b0}} : hi_q;
      OP_MFLO: res_s = busy_s ? {WIDTH{1'b0}} : lo_q;
      default: res_s = {WIDTH{1'b0}};
    endcase
  end

  assign bus.ALUResult = stall_s ? {WIDTH{1'b0}} : res_s;
  assign bus.Zero      = (addsub_res_s == {WIDTH{1'b0}});
  assign bus.overflow  = (bus.ALUControl == OP_ADD) ? ovf_add_s :
                         (bus.ALUControl == OP_SUB) ? ovf_sub_s : 1'b0;
  assign bus.busy      = busy_s;
  assign bus.stall     = stall_s;
  assign bus.done      = done_q;
  assign bus.hi_out    = hi_q;
  assign bus.lo_out    = lo_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Randomised self-checking bench for alu_muldiv against an arithmetic reference model.
module tb_alu_muldiv;
  localparam int W = 32;
  localparam logic [4:0] C_ADD = 5'b00000, C_ADDU = 5'b00001, C_SUB = 5'b00010;
  localparam logic [4:0] C_AND = 5'b00100, C_MFLO = 5'b10101;
  localparam logic [4:0] C_MULT = 5'b10000, C_MULTU = 5'b10001, C_DIV = 5'b10010, C_DIVU = 5'b10011;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_muldiv_if #(.WIDTH(W), .SHAMT_W(5)) bus ();
  alu_muldiv #(.WIDTH(W), .SHAMT_W(5)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] hi_m, lo_m;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] c, input logic src, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [4:0] s, input logic v);
    bus.ALUControl = c; bus.ALUSrc = src; bus.SrcA = a; bus.RD2 = b;
    bus.SignImm = imm; bus.sa = s; bus.in_valid = v;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [31:0] ref_res(input logic [4:0] c, input logic src, input logic [31:0] a,
                                          input logic [31:0] rd2, input logic [31:0] imm, input logic [4:0] s);
    logic [31:0] b;
    b = src ? imm : rd2;
    case (c)
      5'b00000, 5'b00001: return a + b;
      5'b00010, 5'b00011: return a - b;
      5'b00100: return a & rd2;
      5'b00101: return a | rd2;
      5'b01101: return a ^ rd2;
      5'b01110: return ~(a | rd2);
      5'b00110: return rd2 << s;
      5'b00111: return rd2 >> s;
      5'b01011: return 32'($signed(rd2) >>> s);
      5'b01000: return (int'(a) < int'(rd2)) ? 32'd1 : 32'd0;
      5'b01100: return (a < rd2) ? 32'd1 : 32'd0;
      5'b01001, 5'b01010: return a - rd2;
      5'b10100: return hi_m;
      5'b10101: return lo_m;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [4:0] c, input logic src, input logic [31:0] a,
                                   input logic [31:0] rd2, input logic [31:0] imm);
    longint r;
    int ai, bi;
    ai = a;
    bi = src ? imm : rd2;
    if (c == C_ADD) r = longint'(ai) + longint'(bi);
    else if (c == C_SUB) r = longint'(ai) - longint'(bi);
    else r = 64'sd0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  // Returns {HI, LO}.
  function automatic logic [63:0] ref_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int ai, bi, q, r;
    longint ps;
    logic [63:0] pu;
    ai = a; bi = b;
    case (op)
      C_MULT: begin ps = longint'(ai) * longint'(bi); return 64'(ps); end
      C_MULTU: begin pu = {32'd0, a} * {32'd0, b}; return pu; end
      C_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = ai / bi; r = ai % bi;
        return {32'(r), 32'(q)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic wait_done(output int lat, output logic busy_ok);
    logic seen;
    seen = 1'b0; busy_ok = 1'b1; lat = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      tick();
      lat++;
      if (bus.done) seen = 1'b1;
      else if (!bus.busy) busy_ok = 1'b0;
    end
    if (!seen) lat = -1;
  endtask

  task automatic run_md(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    int lat;
    logic busy_ok;
    e = ref_md(op, a, b);
    drive(op, $urandom_range(0, 1), a, b, $urandom(), 5'd0, 1'b1);
    #1;
    check_eq({tag, "_nostall"}, bus.stall, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    check_eq({tag, "_busy"}, bus.busy, 1'b1);
    wait_done(lat, busy_ok);
    check_eq({tag, "_lat"}, 64'(lat), 64'(W + 1));
    check_eq({tag, "_busy_held"}, busy_ok, 1'b1);
    check_eq({tag, "_hi"}, bus.hi_out, e[63:32]);
    check_eq({tag, "_lo"}, bus.lo_out, e[31:0]);
    check_eq({tag, "_idle_at_done"}, bus.busy, 1'b0);
    hi_m = e[63:32];
    lo_m = e[31:0];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] codes [20];
    logic [4:0] c;
    logic src, stall_ok, busy_ok, no_done;
    logic [31:0] a, b, imm, r;
    logic [4:0] s;
    int lat;

    codes = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b01101, 5'b01110,
              5'b00110, 5'b00111, 5'b01011, 5'b01000, 5'b01100, 5'b01001, 5'b01010, 5'b10100,
              5'b10101, 5'b01111, 5'b11000, 5'b11111};
    hi_m = 32'd0; lo_m = 32'd0;
    reset = 1'b1;
    drive(5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    repeat (3) tick();
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_done", bus.done, 1'b0);
    check_eq("rst_hi", bus.hi_out, 32'd0);
    check_eq("rst_lo", bus.lo_out, 32'd0);
    reset = 1'b0;
    tick();

    // Directed add/sub boundaries.
    drive(C_ADD, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'd0, 5'd0, 1'b1); #1;
    check_eq("add_res", bus.ALUResult, 32'h8000_0000);
    check_eq("add_ovf", bus.overflow, 1'b1);
    check_eq("add_zero", bus.Zero, 1'b0);
    drive(C_ADDU, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'd0, 5'd0, 1'b1); #1;
    check_eq("addu_ovf", bus.overflow, 1'b0);
    drive(C_ADD, 1'b1, 32'd5, 32'd123, 32'hFFFF_FFFB, 5'd0, 1'b1); #1;
    check_eq("addi_res", bus.ALUResult, 32'd0);
    check_eq("addi_zero", bus.Zero, 1'b1);
    drive(C_SUB, 1'b0, 32'h8000_0000, 32'd1, 32'd0, 5'd0, 1'b1); #1;
    check_eq("sub_ovf", bus.overflow, 1'b1);
    tick();

    // Directed mul/div.
    run_md("mult", C_MULT, 32'hFFFF_FFFF, 32'd2);
    run_md("multu", C_MULTU, 32'hFFFF_FFFF, 32'd2);
    run_md("div_neg", C_DIV, 32'hFFFF_FFF9, 32'd2);
    run_md("divu_0", C_DIVU, 32'h1234_5678, 32'd0);
    run_md("div_min", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_md("div_0", C_DIV, 32'hFFFF_FF00, 32'd0);

    // MULT then MFLO held: stall until done, AND mid-way passes through.
    drive(C_MULT, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 5'd0, 1'b1);
    tick();
    drive(C_MFLO, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 5'd0, 1'b1); #1;
    stall_ok = bus.stall & (bus.ALUResult == 32'd0);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (bus.done) begin lat = k; break; end
      if (!(bus.stall && bus.ALUResult == 32'd0)) stall_ok = 1'b0;
      if (k == 5) begin
        bus.ALUControl = C_AND; #1;
        check_eq("and_busy_stall", bus.stall, 1'b0);
        check_eq("and_busy_res", bus.ALUResult, 32'h00F0_1200);
        bus.ALUControl = C_MFLO; #1;
      end
    end
    check_eq("mflo_stall_held", stall_ok, 1'b1);
    check_eq("mflo_lat", 64'(lat), 64'(W + 1));
    check_eq("mflo_done_stall", bus.stall, 1'b0);
    check_eq("mflo_done_res", bus.ALUResult, 32'hFFFF_FFFE);
    hi_m = 32'hFFFF_FFFF; lo_m = 32'hFFFF_FFFE;
    bus.in_valid = 1'b0;
    tick();

    // DIVU by zero with a MULTU held behind it: accepted only in the done cycle.
    drive(C_DIVU, 1'b0, 32'h1234_5678, 32'd0, 32'd0, 5'd0, 1'b1);
    tick();
    drive(C_MULTU, 1'b0, 32'd3, 32'd5, 32'd0, 5'd0, 1'b1);
    wait_done(lat, busy_ok);
    check_eq("held_lat", 64'(lat), 64'(W + 1));
    check_eq("held_hi", bus.hi_out, 32'h1234_5678);
    check_eq("held_lo", bus.lo_out, 32'hFFFF_FFFF);
    check_eq("held_done_stall", bus.stall, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    check_eq("held_accept", bus.busy, 1'b1);
    wait_done(lat, busy_ok);
    check_eq("held2_lat", 64'(lat), 64'(W + 1));
    check_eq("held2_lo", bus.lo_out, 32'd15);
    check_eq("held2_hi", bus.hi_out, 32'd0);
    hi_m = 32'd0; lo_m = 32'd15;
    tick();

    // Random single-cycle ops.
    for (int i = 0; i < 150; i++) begin
      c = codes[$urandom_range(0, 19)];
      src = 1'($urandom_range(0, 1));
      a = pick(); b = pick(); imm = pick(); s = 5'($urandom_range(0, 31));
      drive(c, src, a, b, imm, s, 1'($urandom_range(0, 1)));
      #1;
      r = ref_res(c, src, a, b, imm, s);
      check_eq($sformatf("comb_res_c%0h", c), bus.ALUResult, r);
      check_eq($sformatf("comb_ovf_c%0h", c), bus.overflow, ref_ovf(c, src, a, b, imm));
      if (c[4:2] == 3'b000 || c == 5'b01001 || c == 5'b01010)
        check_eq($sformatf("comb_zero_c%0h", c), bus.Zero, (r == 32'd0));
      tick();
    end

    // Random mul/div.
    for (int i = 0; i < 30; i++) begin
      c = 5'b10000 | 5'($urandom_range(0, 3));
      run_md($sformatf("rmd%0d_op%0h", i, c), c, pick(), pick());
    end

    // HI/LO move codes: writes only with the optional feature built in.
    drive(5'b10110, 1'b0, 32'hA5A5_0F0F, 32'd0, 32'd0, 5'd0, 1'b1); #1;
    check_eq("mthi_res", bus.ALUResult, 32'd0);
    tick();
`ifdef ALU_MULDIV_HILO_WRITE_EN
    hi_m = 32'hA5A5_0F0F;
`endif
    check_eq("mthi_hi", bus.hi_out, hi_m);
    drive(5'b10111, 1'b0, 32'h0102_0304, 32'd0, 32'd0, 5'd0, 1'b1); #1;
    check_eq("mtlo_res", bus.ALUResult, 32'd0);
    tick();
`ifdef ALU_MULDIV_HILO_WRITE_EN
    lo_m = 32'h0102_0304;
`endif
    check_eq("mtlo_lo", bus.lo_out, lo_m);
    bus.in_valid = 1'b0;

    // Reset in the middle of a DIV.
    run_md("pre_rst", C_MULT, 32'hFFFF_FFFF, 32'd2);
    drive(C_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd0, 5'd0, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midrst_busy", bus.busy, 1'b0);
    check_eq("midrst_hi", bus.hi_out, 32'd0);
    check_eq("midrst_lo", bus.lo_out, 32'd0);
    check_eq("midrst_done", bus.done, 1'b0);
    no_done = 1'b1;
    repeat (40) begin
      tick();
      if (bus.done) no_done = 1'b0;
    end
    check_eq("midrst_no_done", no_done, 1'b1);
    hi_m = 32'd0; lo_m = 32'd0;
    run_md("post_rst", C_MULTU, 32'd3, 32'd5);
    check_eq("post_rst_lo15", bus.lo_out, 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised next-generation MIPS execute-stage ALU. Keeps single-cycle combinational integer ops and adds a multi-cycle radix-2 multiply/divide unit with architectural HI/LO registers.
- Sits between the register-file read ports and the EX/MEM boundary.
- Raises `stall` to the hazard unit while a mul/div is in flight.

Parameters:
- WIDTH, 32, datapath width in bits; legal values 8..64.
- SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  an instruction is presented this cycle.
- ALUSrc  in  1  1: second operand is SignImm; 0: second operand is RD2 (add/sub class only).
- SrcA  in  WIDTH  first operand.
- RD2  in  WIDTH  second register operand.
- SignImm  in  WIDTH  sign-extended immediate.
- sa  in  SHAMT_W  shift amount.
- ALUControl  in  5  operation select.
- ALUResult  out  WIDTH  result.
- Zero  out  1  1 when the add/sub result == 0.
- overflow  out  1  signed overflow; ADD/SUB only.
- busy  out  1  mul/div engine occupied.
- stall  out  1  the presented op must be held.
- done  out  1  one-cycle pulse when HI/LO are updated.
- hi_out  out  WIDTH  HI register.
- lo_out  out  WIDTH  LO register.

Behaviour:
- Reset is synchronous, active-high, on clk. Reset values: HI=0, LO=0, busy=0, done=0, engine FSM=IDLE.
- Combinational ops, zero latency, independent of busy:
  - 00000 ADD, 00001 ADDU, 00010 SUB, 00011 SUBU: second operand = ALUSrc ? SignImm : RD2.
  - 00100 AND, 00101 OR, 01101 XOR, 01110 NOR: SrcA op RD2.
  - 00110 SLL, 00111 SRL, 01011 SRA: RD2 shifted by sa.
  - 01000 SLT (signed), 01100 SLTU: result 1 or 0.
  - 01001 BEQ, 01010 BNE: ALUResult = SrcA−RD2.
  - Any code not listed here or below: ALUResult = 0.
- Zero: asserted when the add/sub result == 0, for every code.
- overflow: signed-overflow rule, asserted only for codes 00000 and 00010; 0 otherwise.
- Mul/div codes: 10000 MULT, 10001 MULTU, 10010 DIV, 10011 DIVU. Operands are always SrcA and RD2; ALUSrc is ignored.
- Accept rule: in_valid & muldiv code & !busy. At the accept edge E0:
  - Operands and op are latched.
  - busy=1 from E0.
- Engine timing:
  - WIDTH iterations, then one sign-fix cycle.
  - HI/LO are written at edge E(WIDTH+1).
  - At that edge, busy falls and done=1 for exactly one cycle.
  - A new accept is legal in the done cycle.
- FSM states: IDLE → ITER (count WIDTH−1 down to 0) → FIX → IDLE.
- MULT/MULTU results: {HI,LO} = full 2·WIDTH-bit product.
- DIV/DIVU results:
  - LO = quotient, truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - Divide by zero: LO = all ones, HI = SrcA (dividend). Latency is unchanged.
  - Signed INT_MIN / −1: LO = INT_MIN, HI = 0. No trap.
- HI/LO read codes: 10100 MFHI, 10101 MFLO. When !busy: ALUResult = HI or LO.
- stall = in_valid & busy & (muldiv code or MFHI/MFLO or MTHI/MTLO).
  - While stall is high, ALUResult = 0.
  - While stall is high, no second accept occurs.
- Reset mid-operation:
  - Aborts the operation and clears HI/LO.
  - No done pulse is generated.
- hi_out and lo_out always reflect the registers.

Optional Feature:
- Macro: ALU_MULDIV_HILO_WRITE_EN.
- Defined:
  - Code 10110 MTHI: HI ← SrcA at the clock edge.
  - Code 10111 MTLO: LO ← SrcA at the clock edge.
  - Both are single-cycle and stall while busy.
  - ALUResult = 0 for both.
- Undefined:
  - Codes 10110/10111 are treated as unknown: ALUResult = 0, no HI/LO write.
  - Neither code is included in the stall term.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, ALUSrc=0 -> ALUResult=0x80000000, overflow=1, Zero=0. Same operands with ADDU -> overflow=0.
- MULT SrcA=0xFFFFFFFF, RD2=0x00000002 -> done pulse 33 cycles after accept; HI=0xFFFFFFFF, LO=0xFFFFFFFE. Same operands with MULTU -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV SrcA=0xFFFFFFF9 (−7), RD2=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU SrcA=0x12345678, RD2=0 -> LO=0xFFFFFFFF, HI=0x12345678, latency 33 cycles.
- Issue MULT, then MFLO on the next cycle -> stall=1 until the done cycle; in the done cycle MFLO returns the new LO. Also: AND presented while busy -> no stall, correct result.
- Assert reset at iteration 10 of DIV -> on the next cycle busy=0, HI=LO=0, no done pulse. A subsequent MULTU 3×5 -> LO=15, HI=0.
